// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch sequencer: state encoding, opcodes,
// instruction-field constants and small decode helpers.
package fetch_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_MEM   = 3'd3,
    ST_WB    = 3'd4,
    ST_LIIMM = 3'd5,
    ST_DONE  = 3'd6,
    ST_WAIT  = 3'd7
  } state_t;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_BEQ = 3'd1;
  localparam logic [2:0] OP_SB  = 3'd2;
  localparam logic [2:0] OP_LBU = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_OR  = 3'd5;
  localparam logic [2:0] OP_AND = 3'd6;
  localparam logic [2:0] OP_SRL = 3'd7;

  localparam int         INSTR_W  = 9;
  localparam int         OPC_LSB  = 4;
  localparam int         HALT_BIT = 8;
  localparam int         LAT_W    = 3;
  localparam logic [8:0] LI_MASK  = 9'h07C;
  localparam logic [8:0] LI_MATCH = 9'h000;

  function automatic logic [2:0] opcode_of(input logic [INSTR_W-1:0] instr);
    return instr[OPC_LSB +: 3];
  endfunction

  function automatic logic is_li(input logic [INSTR_W-1:0] instr);
    return (instr & LI_MASK) == LI_MATCH;
  endfunction

  function automatic logic is_halt(input logic [INSTR_W-1:0] instr);
    return instr[HALT_BIT];
  endfunction

endpackage

// File: rtl/fetch_sequencer_mem_wait.sv
// mem_wait_timer: loadable down-counter that paces data-memory accesses
// and flags the final access cycle.
module mem_wait_timer
  import fetch_sequencer_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_load,
  input  logic [LAT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_last
);

  logic [LAT_W-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  // A stray zero count is also treated as last so MEM can never stall.
  assign o_last = (r_count <= LAT_W'(1));

endmodule

// File: rtl/fetch_sequencer.sv
// Multicycle fetch/execute sequencer producing registered datapath strobes.
// Define SEQ_STEP_EN to add a Step input that gates every entry into FETCH.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int PC_W    = 10,
  parameter int MEM_LAT = 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
`ifdef SEQ_STEP_EN
  input  logic              Step,
`endif
  input  logic [8:0]        Instr,
  input  logic              Zero,
  input  logic [PC_W-1:0]   BrTarget,
  output logic [PC_W-1:0]   PC,
  output logic              IrLoad,
  output logic              ImmLoad,
  output logic              RegWrite,
  output logic              MemRead,
  output logic              MemWrite,
  output logic              Done,
  output logic [2:0]        State,
  output logic [15:0]       CycleCnt
);

  localparam int               LAT_C   = (MEM_LAT < 1) ? 1 : ((MEM_LAT > 7) ? 7 : MEM_LAT);
  localparam logic [LAT_W-1:0] LAT_VAL = LAT_W'(LAT_C);

  state_t            r_state;
  logic [PC_W-1:0]   r_pc;
  logic [2:0]        r_opcode;
  logic [15:0]       r_cycle_cnt;
  logic              r_ir_load;
  logic              r_imm_load;
  logic              r_reg_write;
  logic              r_mem_read;
  logic              r_mem_write;
  logic              r_done;

  state_t            w_state_next;
  state_t            w_fetch_dest;
  logic [PC_W-1:0]   w_pc_next;
  logic [PC_W-1:0]   w_pc_inc;
  logic [2:0]        w_opcode_next;
  logic              w_fetch_ok;
  logic              w_mem_last;
  logic              w_timer_load;
  logic              w_timer_dec;
  logic              w_counting;

`ifdef SEQ_STEP_EN
  assign w_fetch_ok = Step;
`else
  assign w_fetch_ok = 1'b1;
`endif

  assign w_fetch_dest = w_fetch_ok ? ST_FETCH : ST_WAIT;
  assign w_pc_inc     = r_pc + 1'b1;
  assign w_counting   = (r_state != ST_IDLE) && (r_state != ST_DONE) && (r_state != ST_WAIT);

  always_comb begin
    w_state_next  = r_state;
    w_pc_next     = r_pc;
    w_opcode_next = r_opcode;
    case (r_state)
      ST_IDLE: begin
        w_pc_next = '0;
        if (Start) begin
          w_state_next = w_fetch_dest;
        end
      end
      ST_FETCH: begin
        w_opcode_next = opcode_of(Instr);
        if (is_halt(Instr)) begin
          w_state_next = ST_DONE;
        end else if (is_li(Instr)) begin
          w_pc_next    = w_pc_inc;
          w_state_next = ST_LIIMM;
        end else begin
          w_state_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        // Decisions from here on use the opcode captured in FETCH.
        case (r_opcode)
          OP_BEQ: begin
            w_pc_next    = Zero ? BrTarget : w_pc_inc;
            w_state_next = w_fetch_dest;
          end
          OP_SB, OP_LBU: w_state_next = ST_MEM;
          OP_ADD, OP_XOR, OP_OR, OP_AND, OP_SRL: w_state_next = ST_WB;
          default: w_state_next = ST_WB;
        endcase
      end
      ST_MEM: begin
        if (w_mem_last) begin
          if (r_opcode == OP_SB) begin
            w_pc_next    = w_pc_inc;
            w_state_next = w_fetch_dest;
          end else begin
            w_state_next = ST_WB;
          end
        end
      end
      ST_WB, ST_LIIMM: begin
        w_pc_next    = w_pc_inc;
        w_state_next = w_fetch_dest;
      end
      ST_DONE: begin
        if (!Start) begin
          w_pc_next    = '0;
          w_state_next = ST_IDLE;
        end
      end
`ifdef SEQ_STEP_EN
      ST_WAIT: begin
        if (Step) begin
          w_state_next = ST_FETCH;
        end
      end
`endif
      default: begin
        w_pc_next    = '0;
        w_state_next = ST_IDLE;
      end
    endcase
  end

  assign w_timer_load = (r_state == ST_EXEC) && (w_state_next == ST_MEM);
  assign w_timer_dec  = (r_state == ST_MEM);

  mem_wait_timer u_mem_wait_timer (
    .i_clk      (Clk),
    .i_reset_n  (Reset),
    .i_load     (w_timer_load),
    .i_load_val (LAT_VAL),
    .i_dec      (w_timer_dec),
    .o_last     (w_mem_last)
  );

  // Strobes are decoded from the next state so they line up with State.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_state     <= ST_IDLE;
      r_pc        <= '0;
      r_opcode    <= OP_ADD;
      r_cycle_cnt <= '0;
      r_ir_load   <= 1'b0;
      r_imm_load  <= 1'b0;
      r_reg_write <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_pc        <= w_pc_next;
      r_opcode    <= w_opcode_next;
      r_ir_load   <= (w_state_next == ST_FETCH);
      r_imm_load  <= (w_state_next == ST_LIIMM);
      r_reg_write <= (w_state_next == ST_WB) || (w_state_next == ST_LIIMM);
      r_mem_read  <= (w_state_next == ST_MEM) && (w_opcode_next == OP_LBU);
      r_mem_write <= (w_state_next == ST_MEM) && (w_opcode_next == OP_SB);
      r_done      <= (w_state_next == ST_DONE);
      if ((r_state == ST_IDLE) && (w_state_next != ST_IDLE)) begin
        r_cycle_cnt <= '0;
      end else if (w_counting && (r_cycle_cnt != 16'hFFFF)) begin
        r_cycle_cnt <= r_cycle_cnt + 16'd1;
      end
    end
  end

  assign PC       = r_pc;
  assign State    = r_state;
  assign CycleCnt = r_cycle_cnt;
  assign IrLoad   = r_ir_load;
  assign ImmLoad  = r_imm_load;
  assign RegWrite = r_reg_write;
  assign MemRead  = r_mem_read;
  assign MemWrite = r_mem_write;
  assign Done     = r_done;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed plus randomized bench for fetch_sequencer; an instruction-level
// model expands each word into its expected per-cycle observations.
module tb_fetch_sequencer;

  localparam int LAT = 3;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_EXEC  = 3'd2;
  localparam logic [2:0] S_MEM   = 3'd3;
  localparam logic [2:0] S_WB    = 3'd4;
  localparam logic [2:0] S_LIIMM = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  // Strobe order: IrLoad, ImmLoad, RegWrite, MemRead, MemWrite, Done
  localparam logic [5:0] B_NONE = 6'b000000;
  localparam logic [5:0] B_IR   = 6'b100000;
  localparam logic [5:0] B_IMM  = 6'b010000;
  localparam logic [5:0] B_RW   = 6'b001000;
  localparam logic [5:0] B_MR   = 6'b000100;
  localparam logic [5:0] B_MW   = 6'b000010;
  localparam logic [5:0] B_DONE = 6'b000001;

  logic        Clk;
  logic        Reset;
  logic        Start;
  logic [8:0]  Instr;
  logic        Zero;
  logic [9:0]  BrTarget;
  logic [9:0]  PC;
  logic        IrLoad, ImmLoad, RegWrite, MemRead, MemWrite, Done;
  logic [2:0]  State;
  logic [15:0] CycleCnt;

  int          checks = 0;
  int          errors = 0;
  logic [9:0]  m_pc;
  logic [15:0] m_cnt;

  fetch_sequencer #(.PC_W(10), .MEM_LAT(LAT)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Start    (Start),
`ifdef SEQ_STEP_EN
    .Step     (1'b1),
`endif
    .Instr    (Instr),
    .Zero     (Zero),
    .BrTarget (BrTarget),
    .PC       (PC),
    .IrLoad   (IrLoad),
    .ImmLoad  (ImmLoad),
    .RegWrite (RegWrite),
    .MemRead  (MemRead),
    .MemWrite (MemWrite),
    .Done     (Done),
    .State    (State),
    .CycleCnt (CycleCnt)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic expect_cycle(input string tag, input logic [2:0] s, input logic [5:0] st);
    logic [8:0] obs_ctl;
    logic [8:0] exp_ctl;
    @(negedge Clk);
    obs_ctl = {State, IrLoad, ImmLoad, RegWrite, MemRead, MemWrite, Done};
    exp_ctl = {s, st};
    checks++;
    assert (obs_ctl === exp_ctl) else begin
      errors++;
      $error("FAIL %s_ctl observed=%h expected=%h", tag, obs_ctl, exp_ctl);
    end
    checks++;
    assert (PC === m_pc) else begin
      errors++;
      $error("FAIL %s_pc observed=%h expected=%h", tag, PC, m_pc);
    end
    checks++;
    assert (CycleCnt === m_cnt) else begin
      errors++;
      $error("FAIL %s_cnt observed=%h expected=%h", tag, CycleCnt, m_cnt);
    end
    if (s >= S_FETCH && s <= S_LIIMM && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
  endtask

  // Runs one instruction word starting from its FETCH cycle.
  task automatic run_instr(input logic [8:0] ins, input logic z, input logic [9:0] tgt);
    Instr = ins;
    $display("instr pc=%03h word=%03h zero=%0d tgt=%03h cnt=%0d", m_pc, ins, z, tgt, m_cnt);
    expect_cycle("fetch", S_FETCH, B_IR);
    @(posedge Clk);
    #1;
    Instr    = 9'($urandom);
    Zero     = z;
    BrTarget = tgt;
    Start    = ins[8] ? 1'b1 : 1'($urandom);
    if (ins[8]) begin
      repeat (3) expect_cycle("done", S_DONE, B_DONE);
    end else if (ins[6:2] == 5'b00000) begin
      m_pc = m_pc + 10'd1;
      expect_cycle("liimm", S_LIIMM, B_IMM | B_RW);
      m_pc = m_pc + 10'd1;
    end else begin
      expect_cycle("exec", S_EXEC, B_NONE);
      case (ins[6:4])
        3'd1: m_pc = z ? tgt : m_pc + 10'd1;
        3'd2: begin
          repeat (LAT) expect_cycle("mem_sb", S_MEM, B_MW);
          m_pc = m_pc + 10'd1;
        end
        3'd3: begin
          repeat (LAT) expect_cycle("mem_lbu", S_MEM, B_MR);
          expect_cycle("wb_lbu", S_WB, B_RW);
          m_pc = m_pc + 10'd1;
        end
        default: begin
          expect_cycle("wb", S_WB, B_RW);
          m_pc = m_pc + 10'd1;
        end
      endcase
    end
  endtask

  task automatic leave_done();
    Start = 1'b0;
    m_pc  = '0;
    expect_cycle("idle_after_done", S_IDLE, B_NONE);
  endtask

  task automatic begin_run();
    Start = 1'b1;
    m_pc  = '0;
    m_cnt = '0;
  endtask

  initial begin
    Reset = 1'b0; Start = 1'b0; Instr = '0; Zero = 1'b0; BrTarget = '0;
    m_pc = '0; m_cnt = '0;
    repeat (2) @(posedge Clk);
    expect_cycle("reset", S_IDLE, B_NONE);
    Reset = 1'b1;
    expect_cycle("idle_hold", S_IDLE, B_NONE);

    begin_run();
    run_instr(9'h00C, 1'b0, 10'h000);   // add
    run_instr(9'h040, 1'b0, 10'h000);   // xor
    run_instr(9'h050, 1'b1, 10'h000);   // or
    run_instr(9'h060, 1'b0, 10'h000);   // and
    run_instr(9'h070, 1'b0, 10'h000);   // srl
    run_instr(9'h010, 1'b1, 10'h02A);   // beq taken at pc 5
    run_instr(9'h010, 1'b0, 10'h111);   // beq not taken
    run_instr(9'h010, 1'b1, 10'h005);   // back to pc 5
    run_instr(9'h010, 1'b0, 10'h02A);   // not taken -> 6
    run_instr(9'h020, 1'b0, 10'h000);   // sb
    run_instr(9'h030, 1'b0, 10'h000);   // lbu
    run_instr(9'h010, 1'b1, 10'h3FF);   // jump to last address
    run_instr(9'h003, 1'b0, 10'h000);   // li at 0x3FF wraps
    for (int i = 0; i < 120; i++) begin
      run_instr(9'($urandom_range(0, 255)), 1'($urandom), 10'($urandom));
    end
    run_instr(9'h100, 1'b0, 10'h000);   // halt
    leave_done();

    begin_run();
    run_instr(9'h00C, 1'b0, 10'h000);
    Instr = 9'h030;
    $display("instr pc=%03h word=030 reset in MEM", m_pc);
    expect_cycle("rst_fetch", S_FETCH, B_IR);
    @(posedge Clk);
    #1;
    Instr = 9'($urandom);
    expect_cycle("rst_exec", S_EXEC, B_NONE);
    expect_cycle("rst_mem", S_MEM, B_MR);
    Reset = 1'b0; m_pc = '0; m_cnt = '0;
    expect_cycle("rst_midmem", S_IDLE, B_NONE);
    Reset = 1'b1; Start = 1'b0;
    expect_cycle("rst_idle", S_IDLE, B_NONE);

    begin_run();
    run_instr(9'h030, 1'b0, 10'h000);
    Instr = 9'h001;
    $display("instr pc=%03h word=001 reset in LIIMM", m_pc);
    expect_cycle("rst_li_fetch", S_FETCH, B_IR);
    @(posedge Clk);
    #1;
    Instr = 9'($urandom);
    m_pc = m_pc + 10'd1;
    expect_cycle("rst_li_imm", S_LIIMM, B_IMM | B_RW);
    Reset = 1'b0; m_pc = '0; m_cnt = '0;
    expect_cycle("rst_midli", S_IDLE, B_NONE);
    Reset = 1'b1; Start = 1'b0;
    expect_cycle("rst_li_idle", S_IDLE, B_NONE);

    begin_run();
    run_instr(9'h020, 1'b0, 10'h000);
    run_instr(9'h100, 1'b0, 10'h000);
    leave_done();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL take parameter PC_W, default 10, program counter width.
REQ-002 SHALL take parameter MEM_LAT, default 1, data-memory access cycles (1..7).
REQ-003 SHALL have port Clk, input, 1, the only clock.
REQ-004 SHALL have port Reset, input, 1, synchronous active-low reset.
REQ-005 SHALL have port Start, input, 1, level request to begin execution.
REQ-006 SHALL have port Instr, input, 9, current instruction word at PC; opcode is Instr[6:4], li prefix is Instr[6:2]==00000, halt is Instr[8]==1.
REQ-007 SHALL have port Zero, input, 1, ALU equality flag for beq.
REQ-008 SHALL have port BrTarget, input, PC_W, branch target from lookup.
REQ-009 SHALL have port PC, output, PC_W, instruction address.
REQ-010 SHALL have ports IrLoad, ImmLoad, RegWrite, MemRead, MemWrite, Done, all output, 1, one-hot-style datapath strobes and completion flag.
REQ-011 SHALL have port State, output, 3, current FSM state encoding.
REQ-012 SHALL have port CycleCnt, output, 16, executed-cycle count.

Function
REQ-013 SHALL implement states IDLE=0, FETCH=1, EXEC=2, MEM=3, WB=4, LIIMM=5, DONE=6; all transitions on rising Clk.
REQ-014 IDLE: PC held at 0; Start=1 -> FETCH next cycle; Start=0 -> stay.
REQ-015 FETCH: IrLoad=1 for one cycle; Instr[8]=1 -> DONE; li prefix -> PC<=PC+1, LIIMM; otherwise -> EXEC.
REQ-016 EXEC, opcode add/xor/or/and/srl -> WB; sb/lbu -> MEM with latency counter loaded to MEM_LAT.
REQ-017 EXEC, beq: PC<=BrTarget if Zero=1 else PC+1; -> FETCH; no register or memory strobe.
REQ-018 MEM: MemWrite (sb) or MemRead (lbu) asserted every MEM cycle; counter decrements; at count 1 sb -> PC<=PC+1, FETCH; lbu -> WB.
REQ-019 WB: RegWrite=1 one cycle; PC<=PC+1; -> FETCH.
REQ-020 LIIMM: ImmLoad=1 and RegWrite=1 one cycle; PC<=PC+1; -> FETCH (li costs FETCH+LIIMM = 2 cycles).
REQ-021 DONE: Done=1; PC frozen; Start=0 -> IDLE (PC<=0); Start=1 -> stay.
REQ-022 Start changes outside IDLE/DONE SHALL be ignored.
REQ-023 PC+1 at all-ones SHALL wrap to 0 without error.
REQ-024 CycleCnt SHALL increment each cycle State is not IDLE/DONE, saturate at 0xFFFF, clear on IDLE->FETCH.
REQ-025 Strobes SHALL be Moore outputs decoded from State (and opcode register), zero in IDLE/DONE.
REQ-026 Opcode SHALL be registered in FETCH; EXEC/MEM/WB decisions use the registered copy, not live Instr.
REQ-027 Unused state encoding 7 SHALL return to IDLE next cycle.

Reset
REQ-028 Reset=0 at a rising Clk SHALL force State=IDLE, PC=0, CycleCnt=0, latency counter=0, all strobes and Done=0, regardless of state (including mid-MEM or mid-li).
REQ-029 Reset SHALL take priority over Start and every transition.

Configuration
REQ-030 With SEQ_STEP_EN defined, input Step (1 bit) SHALL exist and FETCH SHALL only be entered from FETCH-bound transitions on a cycle where Step=1; otherwise FSM holds in a WAIT substate encoded as State=7 with strobes 0 and CycleCnt frozen.
REQ-031 Without SEQ_STEP_EN, no Step port SHALL exist and REQ-027 applies to encoding 7.

Structure
REQ-032 Shared package SHALL hold the state enum, opcode constants (ADD, BEQ, SB, LBU, XOR, OR, AND, SRL), li-prefix mask and halt bit index.
REQ-033 Latency counter SHALL be a sub-module mem_wait_timer (load, decrement, last flag).

Verification
REQ-034 Reset, Start=1, Instr=add -> IrLoad at cycle 1, RegWrite at cycle 3, PC=1 at cycle 4.
REQ-035 beq with Zero=1, BrTarget=0x2A at PC=5 -> PC=0x2A after EXEC; with Zero=0 -> PC=6.
REQ-036 lbu with MEM_LAT=3 -> MemRead high exactly 3 cycles, then RegWrite 1 cycle, PC+1.
REQ-037 li prefix at PC=0x3FF -> LIIMM with PC=0, ImmLoad+RegWrite 1 cycle, PC=1.
REQ-038 Halt word (Instr=0x100) -> Done=1, CycleCnt frozen; Start=0 -> IDLE, PC=0; Reset=0 mid-MEM -> all outputs 0 next cycle.
